// File: rtl/pid_seq_pkg.sv
// Shared definitions for the PID lock-acquisition sequencer: widths, defaults, state encodings
// and the lock-window test.
package pid_seq_pkg;

  localparam int unsigned DacW           = 14;
  localparam int unsigned FracDefault    = 16;
  localparam int unsigned CntBitsDefault = 24;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StSweep   = 3'd1;
  localparam state_t StAcquire = 3'd2;
  localparam state_t StLocked  = 3'd3;
  localparam state_t StFault   = 3'd4;

  // Inclusive signed window; an inverted window (lo > hi) can never match.
  function automatic logic in_window(input logic signed [DacW-1:0] v,
                                     input logic signed [DacW-1:0] lo,
                                     input logic signed [DacW-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pid_seq_ramp.sv
// Triangle sweep accumulator with FRAC fractional bits. Clamps to and reverses at the limits;
// clr has priority over load, load over run, otherwise the position holds.
module pid_seq_ramp
  import pid_seq_pkg::*;
#(
  parameter int unsigned FRAC = FracDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   load_i,
  input  logic                   run_i,
  input  logic signed [DacW-1:0] min_i,
  input  logic signed [DacW-1:0] max_i,
  input  logic [FRAC+7:0]        step_i,
  output logic signed [DacW-1:0] pos_o
);

  localparam int unsigned PosW    = DacW + FRAC;
  localparam int unsigned ExtW    = PosW + 2;
  localparam int unsigned StepPad = ExtW - (FRAC + 8);

  logic signed [PosW-1:0] pos_q, pos_d;
  logic                   dir_dn_q, dir_dn_d;

  // Two guard bits so pos +/- step never wraps before the limit compare.
  logic signed [ExtW-1:0] min_x, max_x, pos_x, step_x, sum_x;

  assign min_x  = {{2{min_i[DacW-1]}}, min_i, {FRAC{1'b0}}};
  assign max_x  = {{2{max_i[DacW-1]}}, max_i, {FRAC{1'b0}}};
  assign pos_x  = {{2{pos_q[PosW-1]}}, pos_q};
  assign step_x = {{StepPad{1'b0}}, step_i};
  assign sum_x  = dir_dn_q ? (pos_x - step_x) : (pos_x + step_x);

  always_comb begin
    pos_d    = pos_q;
    dir_dn_d = dir_dn_q;
    if (clr_i) begin
      pos_d    = '0;
      dir_dn_d = 1'b0;
    end else if (load_i) begin
      pos_d    = min_x[PosW-1:0];
      dir_dn_d = 1'b0;
    end else if (run_i) begin
      if (min_i >= max_i) begin
        pos_d = min_x[PosW-1:0];
      end else if (!dir_dn_q) begin
        if (sum_x >= max_x) begin
          pos_d    = max_x[PosW-1:0];
          dir_dn_d = 1'b1;
        end else begin
          pos_d = sum_x[PosW-1:0];
        end
      end else begin
        if (sum_x <= min_x) begin
          pos_d    = min_x[PosW-1:0];
          dir_dn_d = 1'b0;
        end else begin
          pos_d = sum_x[PosW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q    <= '0;
      dir_dn_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      dir_dn_q <= dir_dn_d;
    end
  end

  assign pos_o = pos_q[PosW-1:FRAC];

endmodule

// File: rtl/pid_lock_sequencer.sv
// Lock-acquisition sequencer for one PID channel: sweeps, captures, settles, supervises lock and
// relocks or faults on loss. All outputs are registered from the next state.
module pid_lock_sequencer
  import pid_seq_pkg::*;
#(
  parameter int unsigned FRAC     = FracDefault,
  parameter int unsigned CNT_BITS = CntBitsDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   relock_en_i,
  input  logic signed [DacW-1:0] mon_i,
  input  logic [1:0]             railed_i,
  input  logic signed [DacW-1:0] thr_lo_i,
  input  logic signed [DacW-1:0] thr_hi_i,
  input  logic signed [DacW-1:0] sweep_min_i,
  input  logic signed [DacW-1:0] sweep_max_i,
  input  logic [FRAC+7:0]        sweep_step_i,
  input  logic [CNT_BITS-1:0]    settle_i,
  input  logic [CNT_BITS-1:0]    lost_i,
  output logic                   out_sel_o,
  output logic signed [DacW-1:0] sweep_o,
  output logic                   pid_hold_o,
  output logic                   pid_int_rst_o,
  output logic                   pid_int_ctr_rst_o,
  output logic signed [DacW-1:0] pid_int_ctr_val_o,
  output logic [2:0]             state_o,
  output logic                   locked_o,
  output logic [15:0]            relock_cnt_o
);

  localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);

  state_t                 state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic signed [DacW-1:0] mon_q;
  logic                   in_win, bad;
  logic                   ramp_clr, ramp_load, ramp_run;
  logic                   capture, relock_inc;

  logic                   out_sel_q, pid_hold_q, pid_int_rst_q, pid_int_ctr_rst_q, locked_q;
  logic signed [DacW-1:0] ctr_val_q;
  logic [15:0]            relock_cnt_q;

  assign in_win = in_window(mon_q, thr_lo_i, thr_hi_i);
  assign bad    = !in_win || (railed_i != 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ramp_load  = 1'b0;
    ramp_run   = 1'b0;
    capture    = 1'b0;
    relock_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d   = StSweep;
          ramp_load = 1'b1;
        end
      end
      StSweep: begin
        if (in_win) begin
          state_d = StAcquire;
          cnt_d   = '0;
          capture = 1'b1;
        end else begin
          ramp_run = 1'b1;
        end
      end
      StAcquire: begin
        // Leaving here freezes nothing extra: the ramp simply resumes where it stopped.
        if (!in_win) begin
          state_d = StSweep;
        end else if (cnt_q == settle_i) begin
          state_d = StLocked;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLocked: begin
        if (!bad) begin
          cnt_d = '0;
        end else if (cnt_q == lost_i) begin
          if (relock_en_i) begin
            state_d    = StSweep;
            relock_inc = 1'b1;
          end else begin
            state_d = StFault;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    if (!enable_i) begin
      state_d    = StIdle;
      ramp_load  = 1'b0;
      ramp_run   = 1'b0;
      capture    = 1'b0;
      relock_inc = 1'b0;
    end
  end

  assign ramp_clr = (state_d == StIdle);

  pid_seq_ramp #(
    .FRAC(FRAC)
  ) u_ramp (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (ramp_clr),
    .load_i (ramp_load),
    .run_i  (ramp_run),
    .min_i  (sweep_min_i),
    .max_i  (sweep_max_i),
    .step_i (sweep_step_i),
    .pos_o  (sweep_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      mon_q             <= '0;
      out_sel_q         <= 1'b0;
      pid_hold_q        <= 1'b0;
      pid_int_rst_q     <= 1'b0;
      pid_int_ctr_rst_q <= 1'b0;
      locked_q          <= 1'b0;
      ctr_val_q         <= '0;
      relock_cnt_q      <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      mon_q             <= mon_i;
      out_sel_q         <= (state_d == StSweep);
      pid_int_rst_q     <= (state_d == StSweep);
      pid_hold_q        <= (state_d == StFault);
      locked_q          <= (state_d == StLocked);
      pid_int_ctr_rst_q <= capture;
      if (state_d == StIdle) begin
        ctr_val_q <= '0;
      end else if (capture) begin
        ctr_val_q <= sweep_o;
      end
      if (relock_inc && (relock_cnt_q != 16'hFFFF)) begin
        relock_cnt_q <= relock_cnt_q + 16'd1;
      end
    end
  end

  assign state_o           = state_q;
  assign out_sel_o         = out_sel_q;
  assign pid_hold_o        = pid_hold_q;
  assign pid_int_rst_o     = pid_int_rst_q;
  assign pid_int_ctr_rst_o = pid_int_ctr_rst_q;
  assign pid_int_ctr_val_o = ctr_val_q;
  assign locked_o          = locked_q;
  assign relock_cnt_o      = relock_cnt_q;

endmodule

// File: tb/tb_pid_lock_sequencer.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_pid_lock_sequencer;
  import pid_seq_pkg::*;

  localparam int unsigned FRAC     = 16;
  localparam int unsigned CNT_BITS = 24;

  localparam int SelState   = 0;
  localparam int SelSweep   = 1;
  localparam int SelOutSel  = 2;
  localparam int SelHold    = 3;
  localparam int SelIntRst  = 4;
  localparam int SelCtrRst  = 5;
  localparam int SelCtrVal  = 6;
  localparam int SelLocked  = 7;
  localparam int SelRelock  = 8;

  logic                   clk = 1'b0;
  logic                   rst, enable, relock_en;
  logic signed [DacW-1:0] mon, thr_lo, thr_hi, smin, smax;
  logic [1:0]             railed;
  logic [FRAC+7:0]        step;
  logic [CNT_BITS-1:0]    settle, lost;
  logic                   out_sel, pid_hold, pid_int_rst, pid_int_ctr_rst, locked;
  logic signed [DacW-1:0] sweep, ctr_val;
  logic [2:0]             state;
  logic [15:0]            relock_cnt;

  always #5 clk = ~clk;

  pid_lock_sequencer #(
    .FRAC    (FRAC),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (enable),
    .relock_en_i       (relock_en),
    .mon_i             (mon),
    .railed_i          (railed),
    .thr_lo_i          (thr_lo),
    .thr_hi_i          (thr_hi),
    .sweep_min_i       (smin),
    .sweep_max_i       (smax),
    .sweep_step_i      (step),
    .settle_i          (settle),
    .lost_i            (lost),
    .out_sel_o         (out_sel),
    .sweep_o           (sweep),
    .pid_hold_o        (pid_hold),
    .pid_int_rst_o     (pid_int_rst),
    .pid_int_ctr_rst_o (pid_int_ctr_rst),
    .pid_int_ctr_val_o (ctr_val),
    .state_o           (state),
    .locked_o          (locked),
    .relock_cnt_o      (relock_cnt)
  );

  typedef struct {
    int unsigned cyc;
    int          sel;
    int          val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int sel);
    case (sel)
      SelState:  return int'(state);
      SelSweep:  return int'($signed(sweep));
      SelOutSel: return int'(out_sel);
      SelHold:   return int'(pid_hold);
      SelIntRst: return int'(pid_int_rst);
      SelCtrRst: return int'(pid_int_ctr_rst);
      SelCtrVal: return int'($signed(ctr_val));
      SelLocked: return int'(locked);
      SelRelock: return int'(relock_cnt);
      default:   return -99999;
    endcase
  endfunction

  task automatic expect_v(input int unsigned dt, input int sel, input int val, input string nm);
    exp_t e;
    e.cyc  = cyc + dt;
    e.sel  = sel;
    e.val  = val;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    int act;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = actual(sb[i].sel);
        n_vec++;
        if (sb[i].cyc != cyc || act != sb[i].val) begin
          n_bad++;
          $display("FAIL %s (cycle %0d, due %0d): got %0d, expected %0d",
                   sb[i].name, cyc, sb[i].cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1; enable = 1'b0; relock_en = 1'b1; mon = '0; railed = 2'b00;
    thr_lo = 14'sd1000; thr_hi = 14'sd2000; smin = -14'sd100; smax = 14'sd100;
    step = 24'h010000; settle = 24'd9; lost = 24'd3;

    // Reset state
    tick();
    expect_v(1, SelState, 0, "rst_state");   expect_v(1, SelSweep, 0, "rst_sweep");
    expect_v(1, SelOutSel, 0, "rst_outsel"); expect_v(1, SelIntRst, 0, "rst_intrst");
    expect_v(1, SelHold, 0, "rst_hold");     expect_v(1, SelLocked, 0, "rst_locked");
    expect_v(1, SelRelock, 0, "rst_relock"); expect_v(1, SelCtrRst, 0, "rst_ctrrst");
    expect_v(1, SelCtrVal, 0, "rst_ctrval");
    tick();
    rst = 1'b0;
    expect_v(1, SelState, 0, "idle_disabled"); expect_v(1, SelOutSel, 0, "idle_outsel");
    tick();

    // Enable: sweep starts at minimum
    enable = 1'b1;
    expect_v(1, SelState, 1, "en_state"); expect_v(1, SelSweep, -100, "en_sweep_min");
    expect_v(1, SelOutSel, 1, "en_outsel"); expect_v(1, SelIntRst, 1, "en_intrst");
    tick();

    // Triangle: 200 steps to max, 400-cycle period
    expect_v(199, SelSweep, 99, "ramp_pre_max");
    expect_v(200, SelSweep, 100, "ramp_max");
    expect_v(201, SelSweep, 99, "ramp_reverse");
    expect_v(400, SelSweep, -100, "ramp_min");
    expect_v(401, SelSweep, -99, "ramp_period");
    expect_v(401, SelState, 1, "ramp_state");
    tick(401);

    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if ($signed(sweep) == 14'sd36) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_vec++;
    if (!found) begin
      n_bad++;
      $display("FAIL wait_sweep_36: got %0d, expected 36 within 500 cycles", $signed(sweep));
    end

    // First capture at 37, dropped after 5 in-window acquire cycles
    thr_lo = 14'sd30; thr_hi = 14'sd40; mon = 14'sd37;
    expect_v(1, SelSweep, 37, "cap1_sweep"); expect_v(1, SelState, 1, "cap1_presweep");
    expect_v(2, SelState, 2, "cap1_acq");    expect_v(2, SelCtrVal, 37, "cap1_ctrval");
    expect_v(2, SelCtrRst, 1, "cap1_ctrrst"); expect_v(2, SelOutSel, 0, "cap1_outsel");
    expect_v(2, SelIntRst, 0, "cap1_intrst"); expect_v(2, SelSweep, 37, "cap1_hold");
    expect_v(3, SelCtrRst, 0, "cap1_pulse_end"); expect_v(3, SelState, 2, "cap1_acq2");
    tick(6);
    mon = 14'sd0;
    expect_v(1, SelState, 2, "drop_still_acq");
    expect_v(2, SelState, 1, "drop_sweep");  expect_v(2, SelSweep, 37, "drop_resume");
    expect_v(2, SelOutSel, 1, "drop_outsel");
    expect_v(3, SelSweep, 38, "drop_step");
    tick(3);

    // Second capture at 39, settle=9 -> 10 in-window cycles to lock
    mon = 14'sd37;
    expect_v(1, SelSweep, 39, "cap2_sweep");
    expect_v(2, SelState, 2, "cap2_acq");  expect_v(2, SelCtrVal, 39, "cap2_ctrval");
    expect_v(2, SelCtrRst, 1, "cap2_ctrrst");
    expect_v(11, SelState, 2, "settle_not_yet");
    expect_v(12, SelState, 3, "lock_state"); expect_v(12, SelLocked, 1, "lock_locked");
    expect_v(12, SelOutSel, 0, "lock_outsel"); expect_v(12, SelIntRst, 0, "lock_intrst");
    tick(12);

    // lost=3: three bad cycles tolerated
    mon = 14'sd0;
    tick(3);
    mon = 14'sd37;
    expect_v(1, SelState, 3, "bad3_a"); expect_v(2, SelState, 3, "bad3_b");
    expect_v(3, SelState, 3, "bad3_c"); expect_v(3, SelLocked, 1, "bad3_locked");
    tick(3);

    // Four bad cycles -> relock
    mon = 14'sd0;
    expect_v(4, SelState, 3, "bad4_pre");
    expect_v(5, SelState, 1, "relock_state"); expect_v(5, SelRelock, 1, "relock_cnt");
    expect_v(5, SelOutSel, 1, "relock_outsel"); expect_v(5, SelSweep, 39, "relock_resume");
    expect_v(6, SelSweep, 40, "relock_step");
    tick(6);

    // settle=0 locks after a single in-window cycle; relock disabled from here
    settle = 24'd0; relock_en = 1'b0; mon = 14'sd37;
    expect_v(1, SelSweep, 41, "cap3_sweep");
    expect_v(2, SelState, 2, "cap3_acq"); expect_v(2, SelCtrVal, 41, "cap3_ctrval");
    expect_v(3, SelState, 3, "settle0_lock");
    tick(3);

    // Railed high for lost+1 cycles -> FAULT
    railed = 2'b10;
    expect_v(3, SelState, 3, "rail_pre");
    expect_v(4, SelState, 4, "fault_state"); expect_v(4, SelHold, 1, "fault_hold");
    expect_v(4, SelOutSel, 0, "fault_outsel"); expect_v(4, SelLocked, 0, "fault_locked");
    expect_v(4, SelRelock, 1, "fault_relock");
    tick(4);
    railed = 2'b00;
    expect_v(2, SelState, 4, "fault_sticky"); expect_v(2, SelHold, 1, "fault_hold2");
    tick(2);
    enable = 1'b0;
    expect_v(1, SelState, 0, "dis_idle"); expect_v(1, SelSweep, 0, "dis_sweep");
    expect_v(1, SelHold, 0, "dis_hold");  expect_v(1, SelRelock, 1, "dis_relock_kept");
    expect_v(1, SelCtrVal, 0, "dis_ctrval");
    tick();

    // Reset in the middle of ACQUIRE
    enable = 1'b1;
    expect_v(1, SelState, 1, "re_en_sweep"); expect_v(1, SelSweep, -100, "re_en_min");
    expect_v(2, SelState, 2, "re_acq");      expect_v(2, SelCtrVal, -100, "re_ctrval");
    tick(2);
    rst = 1'b1;
    expect_v(1, SelState, 0, "mid_rst_state"); expect_v(1, SelRelock, 0, "mid_rst_relock");
    expect_v(1, SelCtrVal, 0, "mid_rst_ctrval"); expect_v(1, SelSweep, 0, "mid_rst_sweep");
    expect_v(1, SelOutSel, 0, "mid_rst_outsel");
    tick();
    rst = 1'b0; mon = 14'sd0;
    expect_v(1, SelState, 1, "post_rst_sweep"); expect_v(1, SelSweep, -100, "post_rst_min");
    tick();

    // min >= max: position pinned at min
    smin = 14'sd20; smax = 14'sd10;
    expect_v(1, SelSweep, 20, "inv_lim_a"); expect_v(2, SelSweep, 20, "inv_lim_b");
    expect_v(2, SelState, 1, "inv_lim_state");
    tick(2);

    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
